add_sub_seq_ctrl: RTL and testbench
===================================

// Module: add_sub_seq_ctrl
// PURPOSE
//  Sequencing controller for the 3-bit sign-magnitude add/sub datapath of the bit calculator.
//  - Accepts a token stream over a valid/ready handshake: operand A, operator, operand B, or clear.
//  - Drives the registered operands and operation to the external add_sub datapath.
//  - Waits DP_WAIT cycles, captures the 5-bit result and offers it on a valid/ready result port.
//  - Normalises negative zero on input, flags out-of-order tokens and counts completed operations.
// PARAMETERS
//  DP_WAIT  1  cycles operands are held before dp_c is sampled (>=1; 1 = combinational datapath)
//  CNT_W    8  width of the completed-operation counter (saturating)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      token valid
//  in_ready   out  1      token accepted when in_valid & in_ready at a clk edge
//  in_kind    in   2      00 operand, 01 op ADD, 10 op SUB, 11 CLEAR
//  in_data    in   3      operand, sign-magnitude: [2]=sign, [1:0]=magnitude (ignored unless kind=00)
//  dp_op      out  1      to datapath: 0 add, 1 subtract
//  dp_a       out  3      to datapath: operand A, sign-magnitude, never 3'b100
//  dp_b       out  3      to datapath: operand B, sign-magnitude, never 3'b100
//  dp_c       in   5      from datapath: [4]=sign, [3]=0, [2:0]=magnitude
//  res_valid  out  1      result available
//  res_ready  in   1      result consumed when res_valid & res_ready at a clk edge
//  res_data   out  5      captured result, same format as dp_c
//  err        out  1      one-cycle pulse: accepted token illegal for current state
//  op_count   out  CNT_W  number of results consumed, saturates at all-ones
// BEHAVIOUR
//  Reset (rst_n low, async):
//   - state=IDLE; dp_op, dp_a, dp_b, res_data, op_count, err = 0; res_valid = 0.
//  States:
//   - IDLE   (wait A):  in_ready=1; operand -> latch dp_a -> GOT_A.
//   - GOT_A  (wait op): in_ready=1; ADD/SUB -> latch dp_op (0/1) -> GOT_OP.
//   - GOT_OP (wait B):  in_ready=1; operand -> latch dp_b -> EXEC, wait counter loaded to DP_WAIT-1.
//   - EXEC:  in_ready=0; counter decrements each cycle.
//            At counter==0: res_data<=dp_c, -> DONE. EXEC therefore lasts exactly DP_WAIT cycles.
//   - DONE:  in_ready=0, res_valid=1.
//            On res_ready: op_count++ (saturating), -> IDLE. res_valid may drop the same edge.
//  in_ready and res_valid are decoded from state.
//   - in_ready reads 1 while in reset; no transfer occurs because the flops are held.
//  Latency: B accepted at edge N -> res_valid high from edge N+DP_WAIT.
//  Illegal tokens (accepted, no state change, err=1 the following cycle):
//   - op token in IDLE or GOT_OP.
//   - operand token in GOT_A.
//  CLEAR in IDLE/GOT_A/GOT_OP:
//   - -> IDLE; dp_a/dp_b/dp_op keep their values; no err.
//  Negative zero (in_data=3'b100):
//   - stored as 3'b000 in dp_a/dp_b.
//   - The datapath sign-magnitude converter maps -0 incorrectly, so the datapath must never see it.
//  Operand stability:
//   - dp_a, dp_b, dp_op change only on an accepted token.
//   - They are constant throughout EXEC and DONE.
//  res_data:
//   - held from capture until the next capture; unchanged after res_valid drops.
//   - Range -6..+6: no overflow possible.
//  err pulses back-to-back if illegal tokens are accepted on consecutive cycles.
//  Reset mid-EXEC or mid-DONE: pending result is discarded and op_count is cleared.
// TESTING
//  1. A=011, ADD, B=010, res_ready=1 -> res_data=5'b00101 (+5) DP_WAIT cycles after B; op_count=1.
//  2. A=001, SUB, B=011 -> res_data=5'b10010 (-2). Repeat with DP_WAIT=3: latency is 3 cycles.
//  3. A=100 (-0), ADD, B=101 -> dp_a=000 while in EXEC; res_data=5'b10001 (-1).
//  4. SUB token in IDLE -> err=1 for one cycle, state IDLE. Then A=010, CLEAR -> IDLE, no res_valid.
//  5. res_ready=0 for 5 cycles in DONE -> res_valid=1, res_data and dp_* stable, in_ready=0.
//     Then res_ready=1 -> IDLE; op_count increments once. Also: CNT_W=2, 4 ops -> op_count stays 3.
//  6. rst_n low for 1 cycle during EXEC -> res_valid=0, op_count=0, state IDLE.
//     A new full sequence completes normally.

Source files
------------

// File: rtl/add_sub_seq_ctrl.sv
// Sequencing controller for the 3-bit sign-magnitude add/sub datapath.
// Collects A / operator / B tokens over a valid/ready handshake, drives the
// external datapath with registered operands, waits DP_WAIT cycles, captures
// the result and offers it on a valid/ready result port.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          token handshake
//   in_kind                    00 operand, 01 ADD, 10 SUB, 11 CLEAR
//   in_data                    sign-magnitude operand ([2]=sign)
//   dp_op, dp_a, dp_b          registered operation/operands to the datapath
//   dp_c                       datapath result ([4]=sign, [2:0]=magnitude)
//   res_valid/res_ready        result handshake
//   res_data                   captured result
//   err                        one-cycle pulse on an accepted out-of-order token
//   op_count                   saturating count of consumed results
module add_sub_seq_ctrl #(
    parameter int unsigned DP_WAIT = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [2:0]       in_data,
    output logic             dp_op,
    output logic [2:0]       dp_a,
    output logic [2:0]       dp_b,
    input  logic [4:0]       dp_c,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [4:0]       res_data,
    output logic             err,
    output logic [CNT_W-1:0] op_count
);

    localparam int unsigned WAIT_W = (DP_WAIT > 1) ? $clog2(DP_WAIT) : 1;

    localparam logic [1:0] K_OPND = 2'b00;
    localparam logic [1:0] K_ADD  = 2'b01;
    localparam logic [1:0] K_SUB  = 2'b10;
    localparam logic [1:0] K_CLR  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GOT_A  = 3'd1,
        S_GOT_OP = 3'd2,
        S_EXEC   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [WAIT_W-1:0] wait_cnt;

    logic       accept;
    logic       opnd_tok;
    logic       op_tok;
    logic       clr_tok;
    logic       illegal;
    logic       exec_done;
    logic       res_take;
    logic [2:0] opnd_norm;

    assign accept    = in_valid & in_ready;
    assign opnd_tok  = (in_kind == K_OPND);
    assign op_tok    = (in_kind == K_ADD) | (in_kind == K_SUB);
    assign clr_tok   = (in_kind == K_CLR);
    assign exec_done = (state == S_EXEC) && (wait_cnt == '0);
    assign res_take  = res_valid & res_ready;

    // Negative zero is folded to +0: the datapath converter mishandles it.
    assign opnd_norm = (in_data == 3'b100) ? 3'b000 : in_data;

    // Tokens that arrive out of order are consumed but leave the state alone.
    assign illegal = (op_tok & ((state == S_IDLE) | (state == S_GOT_OP)))
                   | (opnd_tok & (state == S_GOT_A));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept && opnd_tok) state_nx = S_GOT_A;
            end
            S_GOT_A: begin
                if (accept && op_tok)       state_nx = S_GOT_OP;
                else if (accept && clr_tok) state_nx = S_IDLE;
            end
            S_GOT_OP: begin
                if (accept && opnd_tok)     state_nx = S_EXEC;
                else if (accept && clr_tok) state_nx = S_IDLE;
            end
            S_EXEC: begin
                if (wait_cnt == '0) state_nx = S_DONE;
            end
            S_DONE: begin
                if (res_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        res_valid = 1'b0;
        case (state)
            S_IDLE, S_GOT_A, S_GOT_OP: in_ready  = 1'b1;
            S_DONE:                    res_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand, wait counter, result, error and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_op    <= 1'b0;
            dp_a     <= 3'b000;
            dp_b     <= 3'b000;
            wait_cnt <= '0;
            res_data <= 5'b00000;
            err      <= 1'b0;
            op_count <= '0;
        end else begin
            if (accept && (state == S_IDLE) && opnd_tok) begin
                dp_a <= opnd_norm;
            end
            if (accept && (state == S_GOT_A) && op_tok) begin
                dp_op <= (in_kind == K_SUB);
            end
            // EXEC spans exactly DP_WAIT cycles: load DP_WAIT-1, capture at zero.
            if (accept && (state == S_GOT_OP) && opnd_tok) begin
                dp_b     <= opnd_norm;
                wait_cnt <= WAIT_W'(DP_WAIT - 1);
            end else if ((state == S_EXEC) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end
            if (exec_done) begin
                res_data <= dp_c;
            end
            err <= accept & illegal;
            if (res_take && (op_count != '1)) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_add_sub_seq_ctrl.sv
// Directed bench for add_sub_seq_ctrl: one instance with DP_WAIT=1/CNT_W=8,
// one with DP_WAIT=3/CNT_W=2, each closed around a behavioural add/sub datapath.
module tb_add_sub_seq_ctrl;

    logic clk;
    logic rst_n;

    logic       in_valid  [2];
    logic [1:0] in_kind   [2];
    logic [2:0] in_data   [2];
    logic       res_ready [2];

    logic       in_ready0, in_ready1;
    logic       dp_op0, dp_op1;
    logic [2:0] dp_a0, dp_a1, dp_b0, dp_b1;
    logic [4:0] dp_c0, dp_c1;
    logic       res_valid0, res_valid1;
    logic [4:0] res_data0, res_data1;
    logic       err0, err1;
    logic [7:0] op_count0;
    logic [1:0] op_count1;

    int nvec;
    int nerr;

    // Sampled view of the instance under test
    logic       s_in_ready, s_res_valid, s_err, s_dp_op;
    logic [2:0] s_dp_a, s_dp_b;
    logic [4:0] s_res_data;
    logic [7:0] s_oc;

    // Behavioural sign-magnitude add/sub datapath
    function automatic logic [4:0] dp_model(input logic op, input logic [2:0] a, input logic [2:0] b);
        int va, vb, r;
        va = a[2] ? -int'(a[1:0]) : int'(a[1:0]);
        vb = b[2] ? -int'(b[1:0]) : int'(b[1:0]);
        r  = op ? (va - vb) : (va + vb);
        if (r < 0) return {2'b10, 3'(-r)};
        return {2'b00, 3'(r)};
    endfunction

    assign dp_c0 = dp_model(dp_op0, dp_a0, dp_b0);
    assign dp_c1 = dp_model(dp_op1, dp_a1, dp_b1);

    add_sub_seq_ctrl #(.DP_WAIT(1), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready0),
        .in_kind(in_kind[0]), .in_data(in_data[0]),
        .dp_op(dp_op0), .dp_a(dp_a0), .dp_b(dp_b0), .dp_c(dp_c0),
        .res_valid(res_valid0), .res_ready(res_ready[0]), .res_data(res_data0),
        .err(err0), .op_count(op_count0)
    );

    add_sub_seq_ctrl #(.DP_WAIT(3), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready1),
        .in_kind(in_kind[1]), .in_data(in_data[1]),
        .dp_op(dp_op1), .dp_a(dp_a1), .dp_b(dp_b1), .dp_c(dp_c1),
        .res_valid(res_valid1), .res_ready(res_ready[1]), .res_data(res_data1),
        .err(err1), .op_count(op_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int k);
        if (k == 0) begin
            s_in_ready = in_ready0; s_res_valid = res_valid0; s_err = err0;
            s_dp_op = dp_op0; s_dp_a = dp_a0; s_dp_b = dp_b0;
            s_res_data = res_data0; s_oc = op_count0;
        end else begin
            s_in_ready = in_ready1; s_res_valid = res_valid1; s_err = err1;
            s_dp_op = dp_op1; s_dp_a = dp_a1; s_dp_b = dp_b1;
            s_res_data = res_data1; s_oc = {6'b0, op_count1};
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int k, input logic [1:0] kind, input logic [2:0] data);
        in_valid[k] = 1'b1;
        in_kind[k]  = kind;
        in_data[k]  = data;
        tick();
        in_valid[k] = 1'b0;
    endtask

    // Full A/op/B transaction with res_ready high; checks result after DP_WAIT cycles
    task automatic full_op(input int k, input logic [2:0] a, input logic [1:0] op,
                           input logic [2:0] b, input logic [4:0] exp_res, input int wait_n);
        send(k, 2'b00, a);
        send(k, op, 3'b000);
        send(k, 2'b00, b);
        for (int i = 0; i < wait_n; i++) begin
            sample(k);
            chk("no_res_during_exec", 32'(s_res_valid), 32'd0);
            tick();
        end
        sample(k);
        chk("res_valid_after_wait", 32'(s_res_valid), 32'd1);
        chk("res_data", 32'(s_res_data), 32'(exp_res));
        tick();
        sample(k);
        chk("back_to_idle", 32'(s_in_ready), 32'd1);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; in_kind[k] = 2'b00; in_data[k] = 3'b000; res_ready[k] = 1'b1;
        end
        tick();
        tick();

        // Reset state
        sample(0);
        chk("rst_in_ready", 32'(s_in_ready), 32'd1);
        chk("rst_res_valid", 32'(s_res_valid), 32'd0);
        chk("rst_err", 32'(s_err), 32'd0);
        chk("rst_dp", 32'({s_dp_op, s_dp_a, s_dp_b}), 32'd0);
        chk("rst_res_data", 32'(s_res_data), 32'd0);
        chk("rst_op_count", 32'(s_oc), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: 3 + 2 = +5, one-cycle datapath wait
        send(0, 2'b00, 3'b011);
        sample(0); chk("t1_dp_a", 32'(s_dp_a), 32'b011);
        send(0, 2'b01, 3'b000);
        sample(0); chk("t1_dp_op", 32'(s_dp_op), 32'd0);
        send(0, 2'b00, 3'b010);
        sample(0);
        chk("t1_exec_in_ready", 32'(s_in_ready), 32'd0);
        chk("t1_exec_res_valid", 32'(s_res_valid), 32'd0);
        tick();
        sample(0);
        chk("t1_res_valid", 32'(s_res_valid), 32'd1);
        chk("t1_res_data", 32'(s_res_data), 32'b00101);
        tick();
        sample(0);
        chk("t1_res_dropped", 32'(s_res_valid), 32'd0);
        chk("t1_op_count", 32'(s_oc), 32'd1);

        // 2: 1 - 3 = -2
        full_op(0, 3'b001, 2'b10, 3'b011, 5'b10010, 1);
        sample(0); chk("t2_op_count", 32'(s_oc), 32'd2);

        // 3: -0 + -1 = -1, -0 must reach the datapath as +0
        send(0, 2'b00, 3'b100);
        send(0, 2'b01, 3'b000);
        send(0, 2'b00, 3'b101);
        sample(0); chk("t3_dp_a_negzero", 32'(s_dp_a), 32'b000);
        tick();
        sample(0); chk("t3_res_data", 32'(s_res_data), 32'b10001);
        tick();
        sample(0); chk("t3_op_count", 32'(s_oc), 32'd3);

        // 4: SUB in IDLE is illegal, then CLEAR from GOT_A
        send(0, 2'b10, 3'b000);
        sample(0);
        chk("t4_err_pulse", 32'(s_err), 32'd1);
        chk("t4_stay_idle", 32'(s_in_ready), 32'd1);
        tick();
        sample(0); chk("t4_err_clear", 32'(s_err), 32'd0);
        send(0, 2'b00, 3'b010);
        send(0, 2'b11, 3'b000);
        sample(0);
        chk("t4_clear_no_err", 32'(s_err), 32'd0);
        chk("t4_clear_no_res", 32'(s_res_valid), 32'd0);
        chk("t4_clear_keeps_a", 32'(s_dp_a), 32'b010);
        // An op token now must be illegal, proving CLEAR returned to IDLE
        send(0, 2'b01, 3'b000);
        send(0, 2'b01, 3'b000);
        sample(0); chk("t4_err_back_to_back", 32'(s_err), 32'd1);
        tick();
        sample(0); chk("t4_err_end", 32'(s_err), 32'd0);

        // 5: stall in DONE with res_ready low; -2 - 2 = -4
        res_ready[0] = 1'b0;
        send(0, 2'b00, 3'b110);
        send(0, 2'b10, 3'b000);
        send(0, 2'b00, 3'b010);
        tick();
        in_valid[0] = 1'b1; in_kind[0] = 2'b00; in_data[0] = 3'b001;
        for (int i = 0; i < 5; i++) begin
            sample(0);
            chk("t5_hold_valid", 32'(s_res_valid), 32'd1);
            chk("t5_hold_in_ready", 32'(s_in_ready), 32'd0);
            chk("t5_hold_res", 32'(s_res_data), 32'b10100);
            chk("t5_hold_dp", 32'({s_dp_op, s_dp_a, s_dp_b}), 32'b1_110_010);
            tick();
        end
        in_valid[0] = 1'b0;
        res_ready[0] = 1'b1;
        tick();
        sample(0);
        chk("t5_released", 32'(s_res_valid), 32'd0);
        chk("t5_op_count", 32'(s_oc), 32'd4);
        chk("t5_res_held", 32'(s_res_data), 32'b10100);
        tick();
        sample(0); chk("t5_count_once", 32'(s_oc), 32'd4);

        // DP_WAIT=3, CNT_W=2: latency and saturation
        full_op(1, 3'b001, 2'b10, 3'b011, 5'b10010, 3);
        sample(1); chk("w3_op_count1", 32'(s_oc), 32'd1);
        send(1, 2'b00, 3'b010);
        send(1, 2'b01, 3'b000);
        send(1, 2'b00, 3'b100);
        sample(1); chk("w3_dp_b_negzero", 32'(s_dp_b), 32'b000);
        tick(); tick(); tick();
        sample(1); chk("w3_res_plus2", 32'(s_res_data), 32'b00010);
        tick();
        sample(1); chk("w3_op_count2", 32'(s_oc), 32'd2);
        full_op(1, 3'b111, 2'b10, 3'b111, 5'b00000, 3);
        sample(1); chk("w3_op_count3", 32'(s_oc), 32'd3);
        full_op(1, 3'b011, 2'b01, 3'b011, 5'b00110, 3);
        sample(1); chk("w3_op_count_sat", 32'(s_oc), 32'd3);

        // 6: reset during EXEC
        send(1, 2'b00, 3'b001);
        send(1, 2'b01, 3'b000);
        send(1, 2'b00, 3'b001);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        sample(1);
        chk("t6_rst_res_valid", 32'(s_res_valid), 32'd0);
        chk("t6_rst_op_count", 32'(s_oc), 32'd0);
        chk("t6_rst_in_ready", 32'(s_in_ready), 32'd1);
        sample(0); chk("t6_rst_op_count0", 32'(s_oc), 32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        sample(1); chk("t6_result_discarded", 32'(s_res_valid), 32'd0);
        full_op(0, 3'b011, 2'b01, 3'b010, 5'b00101, 1);
        sample(0); chk("t6_after_op_count", 32'(s_oc), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
